// File: rtl/fetch_boot_ctrl_pkg.sv
// Types and default constants for the fetch boot/load controller.
package fetch_boot_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_HALTED
    } boot_state_e;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0010_0073;
    localparam logic [31:0] MAX_CYCLES_DEFAULT = 32'd100000;

endpackage

// File: rtl/riscv_defines_pkg.sv
// Common RISC-V platform constants shared by the fetch-side blocks.
package riscv_defines_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 8;

endpackage

// File: rtl/fetch_boot_ctrl.sv
// Streams a program into instruction memory, holds the core in reset until the
// last write lands, then runs it until a halt instruction or the watchdog fires.
module fetch_boot_ctrl
    import riscv_defines_pkg::*;
    import fetch_boot_ctrl_pkg::*;
#(
    parameter logic [31:0] MAX_CYCLES = MAX_CYCLES_DEFAULT,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH:0]   load_len,
    input  logic                      ld_valid,
    input  logic [31:0]               ld_data,
    output logic                      ld_ready,
    output logic                      sim_load_en,
    output logic [MEM_ADDR_WIDTH-1:0] sim_addr,
    output logic [31:0]               sim_data,
    output logic                      core_reset,
    input  logic [31:0]               pc,
    input  logic [31:0]               instr,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [31:0]               cycle_count,
    output logic [31:0]               halt_pc
);

    localparam int unsigned AW    = MEM_ADDR_WIDTH;
    localparam int unsigned LEN_W = MEM_ADDR_WIDTH + 1;

    boot_state_e       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              settle_q, settle_d;
    logic              ld_ready_q, ld_ready_d;
    logic              sim_load_en_q, sim_load_en_d;
    logic [AW-1:0]     sim_addr_q, sim_addr_d;
    logic [31:0]       sim_data_q, sim_data_d;
    logic              core_reset_q, core_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic [31:0]       halt_pc_q, halt_pc_d;
    logic              ld_hs;

    // ld_ready_q mirrors state_q==ST_LOAD, so it doubles as the handshake qualifier
    assign ld_hs = ld_ready_q && ld_valid;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        settle_d      = settle_q;
        sim_load_en_d = 1'b0;
        sim_addr_d    = sim_addr_q;
        sim_data_d    = sim_data_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        cycle_count_d = cycle_count_q;
        halt_pc_d     = halt_pc_q;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    len_d         = load_len;
                    cnt_d         = '0;
                    settle_d      = 1'b0;
                    done_d        = 1'b0;
                    timeout_d     = 1'b0;
                    cycle_count_d = '0;
                    state_d       = (load_len == '0) ? ST_SETTLE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_hs) begin
                    sim_load_en_d = 1'b1;
                    sim_addr_d    = cnt_q[AW-1:0];
                    sim_data_d    = ld_data;
                    cnt_d         = cnt_q + LEN_W'(1);
                    // Wide counter so a full-memory load still terminates after the address wraps
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        settle_d = 1'b0;
                        state_d  = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                settle_d = 1'b1;
                if (settle_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cycle_count_d = cycle_count_q + 32'd1;
                // First RUN cycle still shows the pre-release fetch, so it cannot halt
                if ((cycle_count_q != 32'd0) && (instr == HALT_INSTR)) begin
                    done_d    = 1'b1;
                    halt_pc_d = pc;
                    state_d   = ST_HALTED;
                end else if (cycle_count_q == MAX_CYCLES - 32'd1) begin
                    timeout_d = 1'b1;
                    halt_pc_d = pc;
                    state_d   = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ld_ready_d   = (state_d == ST_LOAD);
        core_reset_d = (state_d != ST_RUN);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_SETTLE) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            cnt_q         <= '0;
            settle_q      <= 1'b0;
            ld_ready_q    <= 1'b0;
            sim_load_en_q <= 1'b0;
            sim_addr_q    <= '0;
            sim_data_q    <= '0;
            core_reset_q  <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
            halt_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            settle_q      <= settle_d;
            ld_ready_q    <= ld_ready_d;
            sim_load_en_q <= sim_load_en_d;
            sim_addr_q    <= sim_addr_d;
            sim_data_q    <= sim_data_d;
            core_reset_q  <= core_reset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            cycle_count_q <= cycle_count_d;
            halt_pc_q     <= halt_pc_d;
        end
    end

    assign ld_ready    = ld_ready_q;
    assign sim_load_en = sim_load_en_q;
    assign sim_addr    = sim_addr_q;
    assign sim_data    = sim_data_q;
    assign core_reset  = core_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;
    assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_fetch_boot_ctrl.sv
// Directed bench for fetch_boot_ctrl with a small fetch-stage/memory model.
module tb_fetch_boot_ctrl;
    import riscv_defines_pkg::*;

    localparam int unsigned AW    = MEM_ADDR_WIDTH;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [31:0] HALT  = 32'h0010_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW:0]   load_len;
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_ready;
    logic          sim_load_en;
    logic [AW-1:0] sim_addr;
    logic [31:0]   sim_data;
    logic          core_reset;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [31:0]   cycle_count;
    logic [31:0]   halt_pc;

    logic          mem_clr;
    logic [31:0]   imem [DEPTH];
    logic [AW-1:0] wq_addr [$];
    logic [31:0]   wq_data [$];

    int n_cmp;
    int n_err;

    fetch_boot_ctrl #(
        .MAX_CYCLES (32'd16),
        .HALT_INSTR (HALT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .load_len    (load_len),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .sim_load_en (sim_load_en),
        .sim_addr    (sim_addr),
        .sim_data    (sim_data),
        .core_reset  (core_reset),
        .pc          (pc),
        .instr       (instr),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .halt_pc     (halt_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fetch stage: memory written by the loader, PC held at 0 while core_reset
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) imem[i] <= NOP;
        end else if (sim_load_en) begin
            imem[sim_addr] <= sim_data;
        end
        if (core_reset !== 1'b0) pc <= 32'd0;
        else                     pc <= pc + 32'd4;
    end
    assign instr = imem[pc[AW+1:2]];

    always @(negedge clk) begin
        if (sim_load_en === 1'b1) begin
            wq_addr.push_back(sim_addr);
            wq_data.push_back(sim_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int i, input int halt_at, input logic [31:0] base);
        return (i == halt_at) ? HALT : (base | 32'(i));
    endfunction

    task automatic pulse_start(input logic [AW:0] len);
        start    = 1'b1;
        load_len = len;
        tick();
        start    = 1'b0;
    endtask

    task automatic feed(input int n, input int gap, input int halt_at, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                ld_valid = 1'b0;
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = word(i, halt_at, base);
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic check_writes(input string tag, input int n, input int halt_at, input logic [31:0] base);
        int bad;
        bad = 0;
        check({tag, "_nwr"}, 32'(wq_addr.size()), 32'(n));
        for (int i = 0; i < wq_addr.size() && i < n; i++) begin
            if (wq_addr[i] !== AW'(i) || wq_data[i] !== word(i, halt_at, base)) bad++;
        end
        check({tag, "_bad_wr"}, 32'(bad), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
        check({tag, "_load_en"},  32'(sim_load_en), 32'd0);
        check({tag, "_addr"},     32'(sim_addr), 32'd0);
        check({tag, "_data"},     sim_data, 32'd0);
        check({tag, "_core_rst"}, 32'(core_reset), 32'd1);
        check({tag, "_busy"},     32'(busy), 32'd0);
        check({tag, "_done"},     32'(done), 32'd0);
        check({tag, "_timeout"},  32'(timeout), 32'd0);
        check({tag, "_cyc"},      cycle_count, 32'd0);
        check({tag, "_halt_pc"},  halt_pc, 32'd0);
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && !(done === 1'b1 || timeout === 1'b1); i++) tick();
        check("halt_seen", 32'(done | timeout), 32'd1);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        load_len = '0;
        ld_valid = 1'b0;
        ld_data  = '0;
        mem_clr  = 1'b1;
        repeat (3) tick();
        mem_clr  = 1'b0;
        check_reset_vals("rst");
        reset_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Three words back-to-back, then two settle cycles and the watchdog
        clear_writes();
        pulse_start((AW+1)'(3));
        check("t1_ready", 32'(ld_ready), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        feed(3, 0, -1, 32'hA000_0000);
        check("t1_ready_off", 32'(ld_ready), 32'd0);
        check("t1_last_en", 32'(sim_load_en), 32'd1);
        check("t1_last_addr", 32'(sim_addr), 32'd2);
        check("t1_settle1_rst", 32'(core_reset), 32'd1);
        tick();
        check("t1_settle2_rst", 32'(core_reset), 32'd1);
        check("t1_settle2_en", 32'(sim_load_en), 32'd0);
        check("t1_addr_hold", 32'(sim_addr), 32'd2);
        check("t1_data_hold", sim_data, 32'hA000_0002);
        check("t1_settle2_ready", 32'(ld_ready), 32'd0);
        tick();
        check("t1_run_rst", 32'(core_reset), 32'd0);
        check("t1_run_cyc0", cycle_count, 32'd0);
        check_writes("t1", 3, -1, 32'hA000_0000);
        repeat (15) tick();
        check("t1_cyc15", cycle_count, 32'd15);
        check("t1_to_pre", 32'(timeout), 32'd0);
        tick();
        check("t1_timeout", 32'(timeout), 32'd1);
        check("t1_done", 32'(done), 32'd0);
        check("t1_cyc16", cycle_count, 32'd16);
        check("t1_halt_pc", halt_pc, 32'h3C);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_rst_end", 32'(core_reset), 32'd1);
        repeat (3) tick();
        check("t1_cyc_hold", cycle_count, 32'd16);
        check("t1_to_hold", 32'(timeout), 32'd1);

        // Zero-length load straight to SETTLE; start ignored during RUN
        clear_writes();
        pulse_start((AW+1)'(0));
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_ready", 32'(ld_ready), 32'd0);
        check("t2_to_clr", 32'(timeout), 32'd0);
        check("t2_cyc_clr", cycle_count, 32'd0);
        tick();
        check("t2_settle_rst", 32'(core_reset), 32'd1);
        tick();
        check("t2_run_rst", 32'(core_reset), 32'd0);
        pulse_start((AW+1)'(5));
        check("t2_ign_ready", 32'(ld_ready), 32'd0);
        check("t2_ign_rst", 32'(core_reset), 32'd0);
        check("t2_ign_cyc", cycle_count, 32'd1);
        wait_end(40);
        check("t2_timeout", 32'(timeout), 32'd1);
        check("t2_nwr", 32'(wq_addr.size()), 32'd0);

        // Valid toggling every other cycle, halt instruction at word 4
        clear_writes();
        pulse_start((AW+1)'(5));
        feed(5, 1, 4, 32'hB000_0000);
        check("t3_ready_off", 32'(ld_ready), 32'd0);
        tick();
        check("t3_ready_settle", 32'(ld_ready), 32'd0);
        tick();
        check("t3_run_rst", 32'(core_reset), 32'd0);
        check_writes("t3", 5, 4, 32'hB000_0000);
        repeat (4) tick();
        check("t3_pre_done", 32'(done), 32'd0);
        check("t3_pre_cyc", cycle_count, 32'd4);
        tick();
        check("t3_done", 32'(done), 32'd1);
        check("t3_timeout", 32'(timeout), 32'd0);
        check("t3_halt_pc", halt_pc, 32'h10);
        check("t3_core_rst", 32'(core_reset), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_cyc", cycle_count, 32'd5);

        // Halt on the final watchdog cycle wins over timeout
        clear_writes();
        pulse_start((AW+1)'(16));
        feed(16, 0, 15, 32'hD000_0000);
        repeat (2) tick();
        check("t4_run_rst", 32'(core_reset), 32'd0);
        repeat (15) tick();
        check("t4_pre_done", 32'(done), 32'd0);
        tick();
        check("t4_done", 32'(done), 32'd1);
        check("t4_timeout", 32'(timeout), 32'd0);
        check("t4_halt_pc", halt_pc, 32'h3C);
        check("t4_cyc", cycle_count, 32'd16);

        // Reset after 2 of 5 words with a third word offered at the reset edge
        clear_writes();
        pulse_start((AW+1)'(5));
        feed(2, 0, -1, 32'hE000_0000);
        ld_valid = 1'b1;
        ld_data  = 32'hE000_0002;
        reset_n  = 1'b0;
        tick();
        ld_valid = 1'b0;
        check_reset_vals("t5_rst");
        tick();
        check("t5_no_wr", 32'(sim_load_en), 32'd0);
        check_writes("t5", 2, -1, 32'hE000_0000);
        reset_n = 1'b1;
        tick();
        clear_writes();
        pulse_start((AW+1)'(3));
        feed(3, 0, -1, 32'hF000_0000);
        tick();
        check_writes("t5b", 3, -1, 32'hF000_0000);
        tick();
        check("t5b_run_rst", 32'(core_reset), 32'd0);

        // Full-memory load wraps the address exactly once
        wait_end(40);
        clear_writes();
        pulse_start((AW+1)'(DEPTH));
        feed(DEPTH, 0, -1, 32'hC000_0000);
        check("t6_ready_off", 32'(ld_ready), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_last_addr", 32'(sim_addr), 32'(DEPTH - 1));
        repeat (2) tick();
        check("t6_run_rst", 32'(core_reset), 32'd0);
        check_writes("t6", DEPTH, -1, 32'hC000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
